mem_port_arbiter: RTL

- Shares one unified single-port memory between the instruction-fetch requester (IF) and the load/store requester (DM).
- Sits between PC/fetch logic and the data path on one side, and a fixed-latency memory macro on the other.
- Used by the multi-cycle core variant.
- Allows one outstanding transaction. DM has priority, with a starvation guard that protects IF.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency single-port memory between the instruction
//   fetch requester (IF) and the load/store requester (DM). One transaction
//   is in flight at a time. DM normally wins; after STARVE_LIMIT consecutive
//   DM wins while IF is waiting, IF is forced to win the next arbitration.
//
//   Ports
//     clk, reset                 clock (rising edge), async active-low reset
//     if_req_i/if_addr_i         fetch request (held until granted)
//     if_gnt_o                   fetch accepted (combinational, IDLE only)
//     if_rvalid_o/if_rdata_o     fetch response pulse / held fetch data
//     dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i   load/store request
//     dm_gnt_o                   data request accepted (combinational)
//     dm_rvalid_o/dm_rdata_o     load response pulse / held load data
//     mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  one-cycle memory strobe
//     mem_rdata_i                memory read data
//     busy_o                     high whenever not IDLE
//
//   Optional build macro MEM_ARB_STATS_EN adds:
//     if_stall_cnt_o             cycles IF requested without a grant
//     dm_xact_cnt_o              number of DM grants
//   Both saturate at all-ones and clear on reset.

module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       if_stall_cnt_o,
    output logic [31:0]       dm_xact_cnt_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;     // 1 = DM owns the transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic idle, if_win, dm_win;

    assign idle   = (state_q == S_IDLE);
    assign if_win = if_req_i && (!dm_req_i || (starve_q == STARVE_MAX));
    assign dm_win = dm_req_i && !if_win;

    // Grants are combinational from the state register; gating with reset
    // keeps every output low for the whole time reset is asserted.
    assign if_gnt_o = idle && if_win && reset;
    assign dm_gnt_o = idle && dm_win && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (if_gnt_o || dm_gnt_o) begin
                    owner_d = dm_win;
                    we_d    = dm_win && dm_we_i;
                    addr_d  = dm_win ? dm_addr_i : if_addr_i;
                    wdata_d = dm_win ? dm_wdata_i : 32'h0;
                    state_d = S_ISSUE;
                    if (if_gnt_o)
                        starve_d = '0;
                    else if (if_req_i && (starve_q != STARVE_MAX))
                        starve_d = starve_q + 4'd1;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else if (MEM_LATENCY == 1) begin
                    // Single-cycle memory: data is already valid this cycle.
                    if (owner_q) dm_rdata_d = mem_rdata_i;
                    else         if_rdata_d = mem_rdata_i;
                    state_d = S_RESP;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 4'd1;
                // Counter reaches zero on this edge: capture read data now so
                // the owner's rdata register shows it alongside rvalid.
                if (lat_q == 4'd1) begin
                    if (owner_q) dm_rdata_d = mem_rdata_i;
                    else         if_rdata_d = mem_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req_o   = (state_q == S_ISSUE);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : 32'h0;

    assign if_rvalid_o = (state_q == S_RESP) && !owner_q;
    assign dm_rvalid_o = (state_q == S_RESP) && owner_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign busy_o      = !idle;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_stall_q, dm_xact_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_stall_q <= '0;
            dm_xact_q  <= '0;
        end else begin
            if (if_req_i && !if_gnt_o && (if_stall_q != 32'hFFFF_FFFF))
                if_stall_q <= if_stall_q + 32'd1;
            if (dm_gnt_o && (dm_xact_q != 32'hFFFF_FFFF))
                dm_xact_q <= dm_xact_q + 32'd1;
        end
    end

    assign if_stall_cnt_o = if_stall_q;
    assign dm_xact_cnt_o  = dm_xact_q;
`endif

endmodule
